// File: rtl/deca_sw_pkg.sv
// Shared constants and helpers for the DECA switch debouncer and its register file.
package deca_sw_pkg;

  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_EDGE  = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;

  // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/deca_sw_debounce_bit.sv
// One switch channel: 2-flop synchronizer, stable-time counter and
// registered rise/fall pulses that coincide with the first cycle of a new level.
module deca_sw_debounce_bit
  import deca_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          load;

  assign differ = sync_2 ^ clean;
  assign load   = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync_2 takes last cycle's sync_1, giving two real flop stages.
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= load & sync_2;
      fall   <= load & ~sync_2;
      if (load) clean <= sync_2;
      // Any agreeing cycle restarts the window; a completed window also restarts it.
      if (!differ || load) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/deca_sw_debounce.sv
// Debounced switch PIO: WIDTH debounce channels plus an Avalon-MM register file
// (level, edge capture with W1C, interrupt mask) and a level interrupt.
module deca_sw_debounce
  import deca_sw_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    deca_sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .clean  (sw_clean[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  assign unused_wdata = ^writedata;
  assign edge_clr     = (write && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign irq          = |(edgecapture & irqmask);

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    case (address)
      REG_STATE: rd_mux[WIDTH-1:0] = sw_clean;
      REG_EDGE:  rd_mux[WIDTH-1:0] = edgecapture;
      REG_MASK:  rd_mux[WIDTH-1:0] = irqmask;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
    end else begin
      // Set terms are OR'd after the clear so a same-cycle edge wins over W1C.
      edgecapture <= (edgecapture & ~edge_clr) | sw_rise | sw_fall;
      if (write && address == REG_MASK) irqmask <= writedata[WIDTH-1:0];
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_deca_sw_debounce.sv
// Directed bench for deca_sw_debounce with WIDTH=2, DEBOUNCE_CYCLES=4.
module tb_deca_sw_debounce;

  localparam int WIDTH = 2;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [1:0]       address;
  logic             read;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  deca_sw_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  logic [31:0] rd;
  logic        pulse_seen;

  initial begin
    reset_n = 1'b0; sw_raw = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    tick(2);
    check("rst_clean", 32'(sw_clean), 32'h0);
    check("rst_rise",  32'(sw_rise),  32'h0);
    check("rst_fall",  32'(sw_fall),  32'h0);
    check("rst_irq",   32'(irq),      32'h0);
    check("rst_rdata", readdata,      32'h0);
    reset_n = 1'b1;
    tick(3);

    // Clean step on bit 0: visible exactly 2+DC = 6 edges later.
    sw_raw = 2'b01;
    tick(5);
    check("step_clean_e5", 32'(sw_clean), 32'h0);
    check("step_rise_e5",  32'(sw_rise),  32'h0);
    tick();
    check("step_clean_e6", 32'(sw_clean), 32'h1);
    check("step_rise_e6",  32'(sw_rise),  32'h1);
    check("step_fall_e6",  32'(sw_fall),  32'h0);
    tick();
    check("step_rise_e7",  32'(sw_rise),  32'h0);
    bus_read(2'd1, rd);
    check("step_edge", rd, 32'h1);
    bus_read(2'd0, rd);
    check("step_state", rd, 32'h1);
    tick(3);
    check("rdata_hold", readdata, 32'h1);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check("w1c_clear", rd, 32'h0);

    // Glitch train on bit 0: high/low for 2 cycles each never survives DC cycles.
    pulse_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sw_raw[0] = ~sw_raw[0];
      for (int j = 0; j < 2; j++) begin
        tick();
        pulse_seen |= (|sw_rise) | (|sw_fall);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      pulse_seen |= (|sw_rise) | (|sw_fall);
    end
    check("glitch_clean",  32'(sw_clean),   32'h1);
    check("glitch_pulses", 32'(pulse_seen), 32'h0);
    bus_read(2'd1, rd);
    check("glitch_edge", rd, 32'h0);

    // Interrupt on a bit-1 fall, then cleared by W1C.
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, rd);
    check("mask_rd", rd, 32'h3);
    sw_raw = 2'b11;
    tick(8);
    check("b1_rise_clean", 32'(sw_clean), 32'h3);
    check("b1_rise_irq",   32'(irq),      32'h1);
    bus_write(2'd1, 32'h2);
    check("b1_rise_irq_clr", 32'(irq), 32'h0);
    sw_raw = 2'b01;
    tick(6);
    check("b1_fall_clean", 32'(sw_clean), 32'h1);
    check("b1_fall_pulse", 32'(sw_fall),  32'h2);
    check("b1_fall_irq_pre", 32'(irq),    32'h0);
    tick();
    check("b1_fall_irq", 32'(irq), 32'h1);
    bus_write(2'd1, 32'h2);
    check("b1_w1c_irq", 32'(irq), 32'h0);
    bus_read(2'd1, rd);
    check("b1_w1c_edge", rd, 32'h0);

    // W1C on bit 0 in the same cycle its new rise pulse is captured: set wins.
    sw_raw = 2'b00;
    tick(7);
    check("b0_fall_clean", 32'(sw_clean), 32'h0);
    bus_write(2'd1, 32'h1);
    sw_raw = 2'b01;
    tick(6);
    check("race_rise", 32'(sw_rise), 32'h1);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check("race_edge", rd, 32'h1);
    check("race_irq", 32'(irq), 32'h1);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check("race_w1c_later", rd, 32'h0);

    // Reset mid-count: bit 1 counter at 2 when reset hits.
    sw_raw = 2'b11;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_clean", 32'(sw_clean), 32'h0);
    check("mid_rst_rise",  32'(sw_rise),  32'h0);
    check("mid_rst_fall",  32'(sw_fall),  32'h0);
    check("mid_rst_irq",   32'(irq),      32'h0);
    check("mid_rst_rdata", readdata,      32'h0);
    tick();
    reset_n = 1'b1;
    tick(5);
    check("post_rst_e5", 32'(sw_clean), 32'h0);
    tick();
    check("post_rst_e6", 32'(sw_clean), 32'h3);
    check("post_rst_rise", 32'(sw_rise), 32'h3);
    tick();
    check("post_rst_irq_masked", 32'(irq), 32'h0);
    bus_read(2'd1, rd);
    check("post_rst_edge", rd, 32'h3);
    bus_read(2'd2, rd);
    check("post_rst_mask", rd, 32'h0);

    // Unused address 3.
    bus_write(2'd2, 32'h1);
    bus_read(2'd3, rd);
    check("addr3_rd", rd, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    check("addr3_edge", rd, 32'h3);
    bus_read(2'd2, rd);
    check("addr3_mask", rd, 32'h1);
    check("addr3_irq", 32'(irq), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
